axi_lite_master_engine: RTL and testbench

- Synthesizable, parametrised AXI4-Lite master that replaces the simulation-only BFM master processor with a hardware command engine.
- Accepts write/read commands on a valid/ready command port and issues AXI4-Lite transactions, with up to C_MAX_OUTSTANDING in flight.
- Returns responses in command order on a valid/ready response port.
- Sits between the on-chip sequencer and the AXI4-Lite interconnect of the controller pcore.

---
 rtl/axi_lite_master_engine.sv | 150 +++++++++++++++
 tb/tb_axi_lite_master_engine.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_master_engine.sv
// AXI4-Lite master command engine: queued write/read commands in, in-order responses out.
// Optional watchdog built when AXI_LITE_MASTER_TIMEOUT_EN is defined.
module axi_lite_master_engine #(
    parameter int C_M_AXI_LITE_ADDR_WIDTH = 32,
    parameter int C_M_AXI_LITE_DATA_WIDTH = 32,
    parameter int C_MAX_OUTSTANDING       = 4,
    parameter int C_TIMEOUT_CYCLES        = 1024
) (
    input  logic                                 M_AXI_LITE_ACLK,
    input  logic                                 M_AXI_LITE_ARESET,
    input  logic                                 cmd_valid,
    output logic                                 cmd_ready,
    input  logic                                 cmd_write,
    input  logic [C_M_AXI_LITE_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_LITE_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_LITE_DATA_WIDTH/8-1:0] cmd_wstrb,
    input  logic [2:0]                           cmd_prot,
    output logic                                 rsp_valid,
    input  logic                                 rsp_ready,
    output logic                                 rsp_write,
    output logic [C_M_AXI_LITE_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                           rsp_resp,
    output logic                                 timeout_err,
    output logic [C_M_AXI_LITE_ADDR_WIDTH-1:0]   M_AXI_LITE_AWADDR,
    output logic [2:0]                           M_AXI_LITE_AWPROT,
    output logic                                 M_AXI_LITE_AWVALID,
    input  logic                                 M_AXI_LITE_AWREADY,
    output logic [C_M_AXI_LITE_DATA_WIDTH-1:0]   M_AXI_LITE_WDATA,
    output logic [C_M_AXI_LITE_DATA_WIDTH/8-1:0] M_AXI_LITE_WSTRB,
    output logic                                 M_AXI_LITE_WVALID,
    input  logic                                 M_AXI_LITE_WREADY,
    input  logic [1:0]                           M_AXI_LITE_BRESP,
    input  logic                                 M_AXI_LITE_BVALID,
    output logic                                 M_AXI_LITE_BREADY,
    output logic [C_M_AXI_LITE_ADDR_WIDTH-1:0]   M_AXI_LITE_ARADDR,
    output logic [2:0]                           M_AXI_LITE_ARPROT,
    output logic                                 M_AXI_LITE_ARVALID,
    input  logic                                 M_AXI_LITE_ARREADY,
    input  logic [C_M_AXI_LITE_DATA_WIDTH-1:0]   M_AXI_LITE_RDATA,
    input  logic [1:0]                           M_AXI_LITE_RRESP,
    input  logic                                 M_AXI_LITE_RVALID,
    output logic                                 M_AXI_LITE_RREADY
);
    localparam int CNT_W = $clog2(C_MAX_OUTSTANDING + 1);

    logic [CNT_W-1:0] outstanding;
    logic             cur_write;
    logic             busy, aw_free, w_free, ar_free, slot_free, type_ok, room, rsp_free;
    logic             accept, b_hs, r_hs;

    // A holding register counts as free in the cycle its handshake completes,
    // which keeps one command per cycle when the slave READYs stay high.
    assign aw_free   = !M_AXI_LITE_AWVALID | M_AXI_LITE_AWREADY;
    assign w_free    = !M_AXI_LITE_WVALID  | M_AXI_LITE_WREADY;
    assign ar_free   = !M_AXI_LITE_ARVALID | M_AXI_LITE_ARREADY;
    assign slot_free = cmd_write ? (aw_free & w_free) : ar_free;
    assign busy      = (outstanding != '0);
    assign type_ok   = !busy | (cmd_write == cur_write);
    assign room      = (outstanding < CNT_W'(C_MAX_OUTSTANDING));
    assign cmd_ready = !M_AXI_LITE_ARESET & !timeout_err & room & type_ok & slot_free;
    assign accept    = cmd_valid & cmd_ready;

    // Only the active type's channel may return, and never with nothing in flight.
    assign rsp_free          = !rsp_valid | rsp_ready;
    assign M_AXI_LITE_BREADY = !M_AXI_LITE_ARESET & rsp_free & busy & cur_write;
    assign M_AXI_LITE_RREADY = !M_AXI_LITE_ARESET & rsp_free & busy & !cur_write;
    assign b_hs              = M_AXI_LITE_BVALID & M_AXI_LITE_BREADY;
    assign r_hs              = M_AXI_LITE_RVALID & M_AXI_LITE_RREADY;

    always_ff @(posedge M_AXI_LITE_ACLK) begin
        if (M_AXI_LITE_ARESET) begin
            outstanding        <= '0;
            cur_write          <= 1'b0;
            M_AXI_LITE_AWADDR  <= '0;
            M_AXI_LITE_AWPROT  <= '0;
            M_AXI_LITE_AWVALID <= 1'b0;
            M_AXI_LITE_WDATA   <= '0;
            M_AXI_LITE_WSTRB   <= '0;
            M_AXI_LITE_WVALID  <= 1'b0;
            M_AXI_LITE_ARADDR  <= '0;
            M_AXI_LITE_ARPROT  <= '0;
            M_AXI_LITE_ARVALID <= 1'b0;
            rsp_valid          <= 1'b0;
            rsp_write          <= 1'b0;
            rsp_rdata          <= '0;
            rsp_resp           <= '0;
        end else begin
            if (M_AXI_LITE_AWREADY) M_AXI_LITE_AWVALID <= 1'b0;
            if (M_AXI_LITE_WREADY)  M_AXI_LITE_WVALID  <= 1'b0;
            if (M_AXI_LITE_ARREADY) M_AXI_LITE_ARVALID <= 1'b0;
            if (accept) begin
                cur_write <= cmd_write;
                if (cmd_write) begin
                    M_AXI_LITE_AWADDR  <= cmd_addr;
                    M_AXI_LITE_AWPROT  <= cmd_prot;
                    M_AXI_LITE_AWVALID <= 1'b1;
                    M_AXI_LITE_WDATA   <= cmd_wdata;
                    M_AXI_LITE_WSTRB   <= cmd_wstrb;
                    M_AXI_LITE_WVALID  <= 1'b1;
                end else begin
                    M_AXI_LITE_ARADDR  <= cmd_addr;
                    M_AXI_LITE_ARPROT  <= cmd_prot;
                    M_AXI_LITE_ARVALID <= 1'b1;
                end
            end

            case ({accept, b_hs | r_hs})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase

            if (b_hs) begin
                rsp_valid <= 1'b1;
                rsp_write <= 1'b1;
                rsp_resp  <= M_AXI_LITE_BRESP;
                rsp_rdata <= '0;
            end else if (r_hs) begin
                rsp_valid <= 1'b1;
                rsp_write <= 1'b0;
                rsp_resp  <= M_AXI_LITE_RRESP;
                rsp_rdata <= M_AXI_LITE_RDATA;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    localparam int WD_W = $clog2(C_TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            wd_err;

    // Flag is raised on the edge where the count reaches C_TIMEOUT_CYCLES.
    always_ff @(posedge M_AXI_LITE_ACLK) begin
        if (M_AXI_LITE_ARESET) begin
            wd_cnt <= '0;
            wd_err <= 1'b0;
        end else if (!busy || b_hs || r_hs) begin
            wd_cnt <= '0;
        end else begin
            if (wd_cnt == WD_W'(C_TIMEOUT_CYCLES - 1)) wd_err <= 1'b1;
            if (wd_cnt != WD_W'(C_TIMEOUT_CYCLES))     wd_cnt <= wd_cnt + 1'b1;
        end
    end
    assign timeout_err = wd_err;
`else
    assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_axi_lite_master_engine.sv
// Directed bench for axi_lite_master_engine: vector table plus multi-cycle corner sequences.
module tb_axi_lite_master_engine;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            areset;
    logic            cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0]   cmd_addr;
    logic [DW-1:0]   cmd_wdata;
    logic [DW/8-1:0] cmd_wstrb;
    logic [2:0]      cmd_prot;
    logic            rsp_valid, rsp_ready, rsp_write;
    logic [DW-1:0]   rsp_rdata;
    logic [1:0]      rsp_resp;
    logic            timeout_err;
    logic [AW-1:0]   awaddr, araddr;
    logic [2:0]      awprot, arprot;
    logic            awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
    logic [DW-1:0]   wdata, rdata;
    logic [DW/8-1:0] wstrb;
    logic [1:0]      bresp, rresp;

    axi_lite_master_engine #(
        .C_M_AXI_LITE_ADDR_WIDTH(AW), .C_M_AXI_LITE_DATA_WIDTH(DW),
        .C_MAX_OUTSTANDING(4), .C_TIMEOUT_CYCLES(16)
    ) dut (
        .M_AXI_LITE_ACLK(clk), .M_AXI_LITE_ARESET(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .timeout_err(timeout_err),
        .M_AXI_LITE_AWADDR(awaddr), .M_AXI_LITE_AWPROT(awprot),
        .M_AXI_LITE_AWVALID(awvalid), .M_AXI_LITE_AWREADY(awready),
        .M_AXI_LITE_WDATA(wdata), .M_AXI_LITE_WSTRB(wstrb),
        .M_AXI_LITE_WVALID(wvalid), .M_AXI_LITE_WREADY(wready),
        .M_AXI_LITE_BRESP(bresp), .M_AXI_LITE_BVALID(bvalid), .M_AXI_LITE_BREADY(bready),
        .M_AXI_LITE_ARADDR(araddr), .M_AXI_LITE_ARPROT(arprot),
        .M_AXI_LITE_ARVALID(arvalid), .M_AXI_LITE_ARREADY(arready),
        .M_AXI_LITE_RDATA(rdata), .M_AXI_LITE_RRESP(rresp),
        .M_AXI_LITE_RVALID(rvalid), .M_AXI_LITE_RREADY(rready)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdat;
        logic [3:0]  strb;
        logic [2:0]  prot;
        logic [31:0] s_rdata;
        logic [1:0]  s_resp;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs[5];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input string name);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
        #1 chk(name, cmd_ready, 1'b1);
    endtask

    task automatic run_vec(input int i, input vec_t v);
        cmd_wdata = v.wdat; cmd_wstrb = v.strb; cmd_prot = v.prot;
        issue(v.wr, v.addr, $sformatf("v%0d_cmd_ready", i));
        @(negedge clk); cmd_valid = 1'b0;
        if (v.wr) begin
            chk($sformatf("v%0d_awvalid", i), awvalid, 1'b1);
            chk($sformatf("v%0d_wvalid", i), wvalid, 1'b1);
            chk($sformatf("v%0d_awaddr", i), awaddr, v.addr);
            chk($sformatf("v%0d_awprot", i), awprot, v.prot);
            chk($sformatf("v%0d_wdata", i), wdata, v.wdat);
            chk($sformatf("v%0d_wstrb", i), wstrb, v.strb);
        end else begin
            chk($sformatf("v%0d_arvalid", i), arvalid, 1'b1);
            chk($sformatf("v%0d_araddr", i), araddr, v.addr);
            chk($sformatf("v%0d_arprot", i), arprot, v.prot);
        end
        @(negedge clk);
        chk($sformatf("v%0d_valid_drop", i), awvalid | wvalid | arvalid, 1'b0);
        rdata = v.s_rdata;
        if (v.wr) begin bvalid = 1'b1; bresp = v.s_resp; end
        else      begin rvalid = 1'b1; rresp = v.s_resp; end
        #1 chk($sformatf("v%0d_xready", i), v.wr ? bready : rready, 1'b1);
        @(negedge clk); bvalid = 1'b0; rvalid = 1'b0;
        chk($sformatf("v%0d_rsp_valid", i), rsp_valid, 1'b1);
        chk($sformatf("v%0d_rsp_write", i), rsp_write, v.wr);
        chk($sformatf("v%0d_rsp_rdata", i), rsp_rdata, v.exp_rdata);
        chk($sformatf("v%0d_rsp_resp", i), rsp_resp, v.exp_resp);
        @(negedge clk);
        chk($sformatf("v%0d_rsp_done", i), rsp_valid, 1'b0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'd0, 32'h55AA_55AA, 2'd0, 32'h0, 2'd0};
        vecs[1] = '{1'b0, 32'h0000_0010, 32'h0, 4'h0, 3'd2, 32'hDEAD_BEEF, 2'd0, 32'hDEAD_BEEF, 2'd0};
        vecs[2] = '{1'b1, 32'hFFFF_FFFC, 32'h1234_5678, 4'b0101, 3'd7, 32'hFFFF_FFFF, 2'd2, 32'h0, 2'd2};
        vecs[3] = '{1'b0, 32'h8000_0000, 32'h0, 4'h0, 3'd1, 32'hCAFE_F00D, 2'd3, 32'hCAFE_F00D, 2'd3};
        vecs[4] = '{1'b0, 32'h0000_0000, 32'h0, 4'h0, 3'd0, 32'h0000_0000, 2'd1, 32'h0, 2'd1};

        areset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_wstrb = '0; cmd_prot = '0; rsp_ready = 1'b1;
        awready = 1'b1; wready = 1'b1; arready = 1'b1;
        bvalid = 1'b0; bresp = '0; rvalid = 1'b0; rdata = '0; rresp = '0;
        @(negedge clk); @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_valids", {awvalid, wvalid, arvalid, rsp_valid}, 4'b0);
        chk("rst_readys", {bready, rready}, 2'b0);
        chk("rst_payload", {awaddr, araddr, wdata, 4'(wstrb)}, '0);
        chk("rst_timeout", timeout_err, 1'b0);
        areset = 1'b0;
        @(negedge clk);
        chk("post_rst_cmd_ready", cmd_ready, 1'b1);

        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        // Four pipelined reads fill the window; the fifth stalls, data returns in order.
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 32'(i * 4), $sformatf("pipe_acc%0d", i));
            @(negedge clk);
            chk($sformatf("pipe_arvalid%0d", i), arvalid, 1'b1);
            chk($sformatf("pipe_araddr%0d", i), araddr, 32'(i * 4));
        end
        cmd_addr = 32'h10;
        #1 chk("pipe_stall5", cmd_ready, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("pipe_stall_wait%0d", k), cmd_ready, 1'b0);
        end
        chk("pipe_no_5th_ar", arvalid, 1'b0);
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rvalid = 1'b1; rdata = 32'h1111_0000 + 32'(i); rresp = 2'd0;
            #1 chk($sformatf("pipe_rready%0d", i), rready, 1'b1);
            @(negedge clk);
            chk($sformatf("pipe_rsp_valid%0d", i), rsp_valid, 1'b1);
            chk($sformatf("pipe_rdata%0d", i), rsp_rdata, 32'h1111_0000 + 32'(i));
        end
        rvalid = 1'b0;
        @(negedge clk);
        chk("pipe_rsp_done", rsp_valid, 1'b0);
        chk("pipe_rready_idle", rready, 1'b0);

        // W completes first, AW held off for three cycles.
        awready = 1'b0; cmd_wdata = 32'h0BAD_F00D; cmd_wstrb = 4'h3;
        issue(1'b1, 32'h20, "wfirst_acc");
        @(negedge clk);
        cmd_addr = 32'h24;
        chk("wfirst_both_valid", {awvalid, wvalid}, 2'b11);
        #1 chk("wfirst_aw_busy_stall", cmd_ready, 1'b0);
        @(negedge clk);
        chk("wfirst_wvalid_drop", wvalid, 1'b0);
        chk("wfirst_awvalid_c2", awvalid, 1'b1);
        chk("wfirst_awaddr_c2", awaddr, 32'h20);
        chk("wfirst_stall_c2", cmd_ready, 1'b0);
        @(negedge clk);
        chk("wfirst_awvalid_c3", awvalid, 1'b1);
        chk("wfirst_awaddr_c3", awaddr, 32'h20);
        cmd_valid = 1'b0; awready = 1'b1;
        @(negedge clk);
        chk("wfirst_awvalid_drop", awvalid, 1'b0);
        chk("wfirst_no_early_rsp", rsp_valid, 1'b0);
        bvalid = 1'b1; bresp = 2'd0;
        #1 chk("wfirst_bready", bready, 1'b1);
        @(negedge clk); bvalid = 1'b0;
        chk("wfirst_rsp", {rsp_valid, rsp_write}, 2'b11);
        @(negedge clk);
        chk("wfirst_single_rsp", rsp_valid, 1'b0);

        // Read presented behind a write waits for the write to drain.
        issue(1'b1, 32'h30, "sw_wr_acc");
        @(negedge clk);
        cmd_write = 1'b0; cmd_addr = 32'h34;
        #1 chk("sw_stall0", cmd_ready, 1'b0);
        @(negedge clk);
        chk("sw_stall1", cmd_ready, 1'b0);
        chk("sw_no_ar1", arvalid, 1'b0);
        bvalid = 1'b1; bresp = 2'd0;
        #1 chk("sw_stall_bhs", cmd_ready, 1'b0);
        @(negedge clk); bvalid = 1'b0;
        chk("sw_no_ar2", arvalid, 1'b0);
        chk("sw_wr_rsp", {rsp_valid, rsp_write}, 2'b11);
        #1 chk("sw_rd_ready", cmd_ready, 1'b1);
        @(negedge clk); cmd_valid = 1'b0;
        chk("sw_arvalid", arvalid, 1'b1);
        chk("sw_araddr", araddr, 32'h34);
        @(negedge clk);
        rvalid = 1'b1; rdata = 32'h3434_3434; rresp = 2'd0;
        @(negedge clk); rvalid = 1'b0;
        chk("sw_rd_rsp", {rsp_valid, rsp_write}, 2'b10);
        chk("sw_rd_data", rsp_rdata, 32'h3434_3434);
        @(negedge clk);

        // Response backpressure with two reads in flight.
        rsp_ready = 1'b0;
        issue(1'b0, 32'h40, "bp_acc0");
        @(negedge clk);
        issue(1'b0, 32'h44, "bp_acc1");
        @(negedge clk); cmd_valid = 1'b0;
        @(negedge clk);
        rvalid = 1'b1; rdata = 32'h4040_4040;
        #1 chk("bp_rready0", rready, 1'b1);
        @(negedge clk);
        chk("bp_rsp0_valid", rsp_valid, 1'b1);
        rdata = 32'h4444_4444;
        #1 chk("bp_rready_block", rready, 1'b0);
        for (int k = 0; k < 9; k++) @(negedge clk);
        chk("bp_hold_rready", rready, 1'b0);
        chk("bp_hold_data", rsp_rdata, 32'h4040_4040);
        chk("bp_hold_valid", rsp_valid, 1'b1);
        rsp_ready = 1'b1;
        #1 chk("bp_rready_resume", rready, 1'b1);
        @(negedge clk); rvalid = 1'b0;
        chk("bp_rsp1_valid", rsp_valid, 1'b1);
        chk("bp_rsp1_data", rsp_rdata, 32'h4444_4444);
        @(negedge clk);
        chk("bp_done", rsp_valid, 1'b0);

        // Read that is never answered.
        issue(1'b0, 32'h50, "to_acc");
        @(negedge clk); cmd_valid = 1'b0;
        chk("to_arvalid", arvalid, 1'b1);
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
        for (int k = 1; k <= 15; k++) @(negedge clk);
        chk("to_not_yet", timeout_err, 1'b0);
        @(negedge clk);
        chk("to_set", timeout_err, 1'b1);
        cmd_valid = 1'b1; cmd_write = 1'b0;
        #1 chk("to_cmd_blocked", cmd_ready, 1'b0);
        for (int k = 0; k < 4; k++) @(negedge clk);
        chk("to_sticky", timeout_err, 1'b1);
`else
        for (int k = 0; k < 40; k++) @(negedge clk);
        chk("to_disabled", timeout_err, 1'b0);
`endif
        areset = 1'b1; cmd_valid = 1'b0;
        @(negedge clk);
        chk("rst2_timeout", timeout_err, 1'b0);
        chk("rst2_cmd_ready", cmd_ready, 1'b0);
        chk("rst2_rready", rready, 1'b0);
        areset = 1'b0;
        @(negedge clk);
        chk("rst2_cmd_ready_after", cmd_ready, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
